// File: rtl/gate_sched_pkg.sv
// gate_sched_pkg: FSM state encodings and default widths shared by the gate scheduler and the counter bench.
package gate_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;
  localparam int CNTR_WIDTH_DEF = 8;
  localparam int GATE_W_DEF = 16;
endpackage

// File: rtl/gate_sched_ovf_ext.sv
// gate_sched_ovf_ext: counter-overflow rising-edge detect with sticky flag.
// With GATE_SCHED_OVF_EXTEND_EN a saturating extension counter replaces the sticky bit.
module gate_sched_ovf_ext
`ifdef GATE_SCHED_OVF_EXTEND_EN
  #(parameter int EXT_W = 8)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ovf_in,
`ifdef GATE_SCHED_OVF_EXTEND_EN
  output logic [EXT_W-1:0] ext,
`endif
  output logic flag
);
  logic ovf_d;
  logic rise;
  assign rise = en & ovf_in & ~ovf_d;
`ifdef GATE_SCHED_OVF_EXTEND_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_d <= 1'b0;
      ext <= '0;
    end else begin
      ovf_d <= ovf_in;
      ext <= clr ? '0 : ext + EXT_W'(rise & ~&ext);
    end
  assign flag = &ext;
`else
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_d <= 1'b0;
      flag <= 1'b0;
    end else begin
      ovf_d <= ovf_in;
      flag <= clr ? 1'b0 : flag | rise;
    end
`endif
endmodule

// File: rtl/gate_sched_ctrl.sv
// gate_sched_ctrl: clear / gate / settle / latch sequencer for one peak counter, result held under valid/ack.
// Optional GATE_SCHED_OVF_EXTEND_EN widens result_count with a saturating overflow extension.
module gate_sched_ctrl
  import gate_sched_pkg::*;
#(
  parameter int CNTR_WIDTH = CNTR_WIDTH_DEF,
  parameter int GATE_W = GATE_W_DEF,
  parameter int SETTLE_CYC = 3
`ifdef GATE_SCHED_OVF_EXTEND_EN
  , parameter int EXT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [GATE_W-1:0] gate_len,
  output logic cnt_rst,
  output logic cnt_clken,
  input  logic [CNTR_WIDTH-1:0] cnt_count,
  input  logic cnt_overflow,
  output logic busy,
  output logic result_valid,
  input  logic result_ack,
`ifdef GATE_SCHED_OVF_EXTEND_EN
  output logic [EXT_W+CNTR_WIDTH-1:0] result_count,
`else
  output logic [CNTR_WIDTH-1:0] result_count,
`endif
  output logic result_overflow
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t state;
  logic [GATE_W-1:0] gate_left;
  logic [SW-1:0] settle_cnt;
  logic flag;
`ifdef GATE_SCHED_OVF_EXTEND_EN
  logic [EXT_W-1:0] ext;
  logic [EXT_W+CNTR_WIDTH-1:0] res_next;
  assign res_next = {ext, cnt_count};
  gate_sched_ovf_ext #(.EXT_W(EXT_W)) u_ovf (
    .clk, .rst_n, .clr(state == S_CLEAR), .en(state == S_GATE || state == S_SETTLE),
    .ovf_in(cnt_overflow), .ext, .flag
  );
`else
  logic [CNTR_WIDTH-1:0] res_next;
  assign res_next = cnt_count;
  gate_sched_ovf_ext u_ovf (
    .clk, .rst_n, .clr(state == S_CLEAR), .en(state == S_GATE || state == S_SETTLE),
    .ovf_in(cnt_overflow), .flag
  );
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt_rst <= 1'b0;
      cnt_clken <= 1'b0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result_count <= '0;
      result_overflow <= 1'b0;
      gate_left <= '0;
      settle_cnt <= '0;
    end else begin
      if (result_ack) result_valid <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        cnt_rst <= 1'b0;
        cnt_clken <= 1'b0;
        busy <= 1'b0;
      end else case (state)
        S_IDLE: if (start && gate_len != '0) begin
          state <= S_CLEAR;
          gate_left <= gate_len;
          cnt_rst <= 1'b1;
          busy <= 1'b1;
        end
        S_CLEAR: begin
          state <= S_GATE;
          cnt_rst <= 1'b0;
          cnt_clken <= 1'b1;
        end
        // gate_left only counts down from the loaded length, so the all-ones length cannot wrap
        S_GATE: if (gate_left == GATE_W'(1)) begin
          state <= S_SETTLE;
          cnt_clken <= 1'b0;
          settle_cnt <= '0;
        end else gate_left <= gate_left - 1'b1;
        S_SETTLE: if (settle_cnt == SW'(SETTLE_CYC - 1)) state <= S_DONE;
                  else settle_cnt <= settle_cnt + 1'b1;
        S_DONE: begin
          state <= S_IDLE;
          busy <= 1'b0;
          result_count <= res_next;
          result_overflow <= flag;
          result_valid <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gate_sched_ctrl.sv
// tb_gate_sched_ctrl: directed bench with a timeline model of the scheduler and a pulse-driven counter stand-in.
module tb_gate_sched_ctrl;
  localparam int S = 3;
`ifdef GATE_SCHED_OVF_EXTEND_EN
  localparam int RW = 16;
`else
  localparam int RW = 8;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ack = 1'b0;
  logic [15:0] gate_len = '0;
  logic cnt_rst, cnt_clken, busy, result_valid, result_overflow;
  logic [7:0] cnt_count;
  logic cnt_overflow;
  logic [RW-1:0] result_count;
  int total = 0;
  int bad = 0;
  int plan_p = 0;
  int pdiv = 3;
  logic [7:0] c_cnt = '0;
  logic c_ovf = 1'b0;
  int gc = 0;
  int pl = 0;
  int cyc = 0;
  int e = 0;
  int n = 0;
  bit m_act, m_valid, m_ovf;
  longint m_cnt;
  int hi = 0;

  gate_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .cnt_rst(cnt_rst), .cnt_clken(cnt_clken), .cnt_count(cnt_count), .cnt_overflow(cnt_overflow),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
    .result_count(result_count), .result_overflow(result_overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint res_of(input int p);
`ifdef GATE_SCHED_OVF_EXTEND_EN
    int x = (p / 256 > 255) ? 255 : p / 256;
    return longint'(x * 256 + p % 256);
`else
    return longint'(p % 256);
`endif
  endfunction

  function automatic bit ovf_of(input int p);
`ifdef GATE_SCHED_OVF_EXTEND_EN
    return (p / 256) >= 255;
`else
    return p >= 256;
`endif
  endfunction

  // counter stand-in: plan_p pulses, one every pdiv enabled cycles, overflow pulses on wrap
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_cnt <= '0;
      c_ovf <= 1'b0;
      gc <= 0;
      pl <= 0;
    end else begin
      c_ovf <= 1'b0;
      if (cnt_rst) begin
        c_cnt <= '0;
        gc <= 0;
        pl <= plan_p;
      end else if (cnt_clken) begin
        gc <= gc + 1;
        if (gc % pdiv == 0 && pl > 0) begin
          c_cnt <= c_cnt + 8'd1;
          pl <= pl - 1;
          c_ovf <= (c_cnt == 8'hff);
        end
      end
    end
  assign cnt_count = c_cnt;
  assign cnt_overflow = c_ovf;

  // timeline model: a measurement accepted at edge e clears at e, gates e+1..e+n, latches at e+n+S+2
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_act = 0;
      m_valid = 0;
      m_cnt = 0;
      m_ovf = 0;
    end else begin
      cyc++;
      if (result_ack) m_valid = 0;
      if (abort) m_act = 0;
      else if (m_act && cyc == e + n + S + 2) begin
        m_act = 0;
        m_valid = 1;
        m_cnt = res_of(plan_p);
        m_ovf = ovf_of(plan_p);
      end else if (!m_act && start && gate_len != 0) begin
        m_act = 1;
        e = cyc;
        n = int'(gate_len);
      end
    end

  always @(negedge clk) begin
    chk("busy", busy, m_act);
    chk("cnt_rst", cnt_rst, m_act && cyc == e);
    chk("cnt_clken", cnt_clken, m_act && cyc > e && cyc <= e + n);
    chk("result_valid", result_valid, m_valid);
    chk("result_count", result_count, m_cnt);
    chk("result_overflow", result_overflow, m_ovf);
    if (cnt_rst) hi = 0;
    else if (cnt_clken) hi++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input int len);
    gate_len = 16'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int k = 0;
    while (!result_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", result_valid, 1'b1);
  endtask

  task automatic ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  initial begin
    int s;
    int v;
    repeat (2) tick();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_clken", cnt_clken, 0);
    chk("rst_count", result_count, 0);
    rst_n = 1'b1;
    tick();
    plan_p = 10;
    pdiv = 3;
    s = cyc + 1;
    do_start(100);
    wait_valid(300);
    chk("basic_latency", cyc - s, 105);
    chk("basic_gate_len", hi, 100);
    chk("basic_count", result_count, 10);
    chk("basic_ovf", result_overflow, 0);
    tick();
    ack();
    plan_p = 261;
    pdiv = 2;
    do_start(600);
    wait_valid(800);
`ifdef GATE_SCHED_OVF_EXTEND_EN
    chk("wrap_count", result_count, 'h105);
    chk("wrap_ovf", result_overflow, 0);
`else
    chk("wrap_count", result_count, 5);
    chk("wrap_ovf", result_overflow, 1);
`endif
    tick();
    ack();
    do_start(0);
    #1;
    chk("zero_busy", busy, 0);
    chk("zero_clear", cnt_rst, 0);
    tick();
    gate_len = 16'd50;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("abort_start_busy", busy, 0);
    plan_p = 3;
    pdiv = 3;
    do_start(20);
    repeat (5) tick();
    do_start(50);
    wait_valid(100);
    chk("busy_start_gate_len", hi, 20);
    chk("busy_start_count", result_count, 3);
    tick();
    ack();
    plan_p = 20;
    do_start(100);
    repeat (40) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    chk("abort_clken", cnt_clken, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_prev_count", result_count, 3);
    repeat (150) tick();
    chk("abort_no_latch", result_valid, 0);
    plan_p = 2;
    do_start(10);
    wait_valid(50);
    chk("hs_count", result_count, 2);
    v = 0;
    repeat (50) begin
      tick();
      v += int'(result_valid);
    end
    chk("hs_hold", v, 50);
    ack();
    #1;
    chk("hs_drop", result_valid, 0);
    do_start(10);
    #1;
    chk("hs_restart_busy", busy, 1);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_clken", cnt_clken, 0);
    chk("arst_cnt_rst", cnt_rst, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_count", result_count, 0);
    chk("arst_ovf", result_overflow, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("arst_idle", busy, 0);
    repeat (20) tick();
    chk("arst_no_latch", result_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gate_sched_ctrl.md
Name: gate_sched_ctrl

Overview:
- Gate-time scheduler for the synchronous n-bit peak counter (`counter_nbit_sync`).
- On a start command it performs three steps:
  - clears the counter;
  - opens the count gate (drives the counter's clken) for a programmable number of clock cycles;
  - waits for the counter's input synchronizer to drain, then latches count and overflow into a result register.
- The result is held for the USB readout side under a valid/ack handshake.
- Sits between the host command/register interface and one counter instance.

Parameters:
- CNTR_WIDTH, 8, width of counter count_out and of result_count (base).
- GATE_W, 16, width of gate_len; maximum gate is 2**GATE_W-1 cycles.
- SETTLE_CYC, 3, cycles waited after gate close before sampling (covers sig_in sync stages plus count register).
- EXT_W, 8, extension width used only with OVF_EXTEND_EN.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin a measurement (honoured only in IDLE).
- abort  in  1  one-cycle pulse: cancel any measurement, return to IDLE.
- gate_len  in  GATE_W  gate length in clk cycles, sampled on accepted start.
- cnt_rst  out  1  synchronous clear to counter rst, active-high.
- cnt_clken  out  1  counter clock enable (gate).
- cnt_count  in  CNTR_WIDTH  counter count_out.
- cnt_overflow  in  1  counter overflow_out.
- busy  out  1  high in any state except IDLE.
- result_valid  out  1  result registers hold a new measurement.
- result_ack  in  1  readout consumed result; clears result_valid.
- result_count  out  CNTR_WIDTH (+EXT_W with OVF_EXTEND_EN)  latched count.
- result_overflow  out  1  sticky: counter wrapped at least once during gate (with OVF_EXTEND_EN: extension saturated).

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE;
  - cnt_rst=0, cnt_clken=0, busy=0, result_valid=0;
  - result_count=0, result_overflow=0;
  - gate counter=0, settle counter=0, ovf_d=0.
- All outputs are registered.
- FSM:
  - IDLE:
    - start=1 and gate_len!=0 -> CLEAR; latch gate_len into gate_left.
    - start with gate_len=0 is ignored; the FSM stays in IDLE.
  - CLEAR: exactly 1 cycle; cnt_rst=1, cnt_clken=0, sticky overflow cleared -> GATE.
  - GATE:
    - cnt_clken=1 for exactly gate_len consecutive cycles;
    - gate_left decrements; when it reaches 1 -> SETTLE.
  - SETTLE: cnt_clken=0; count SETTLE_CYC cycles -> DONE.
  - DONE:
    - on entry: result_count<=cnt_count, result_overflow<=sticky, result_valid<=1 (same edge);
    - next cycle -> IDLE.
- result_valid:
  - stays 1 until a cycle with result_ack=1 clears it;
  - result_ack while result_valid=0 is ignored;
  - a new latch while result_valid=1 overwrites the result and leaves result_valid=1.
- Latency, start to result_valid: 1 (CLEAR) + gate_len + SETTLE_CYC + 1 cycles, counted from the start-sample edge.
- Overflow detection:
  - ovf_d registers cnt_overflow;
  - a rising edge (cnt_overflow & ~ovf_d) during GATE or SETTLE sets sticky.
- start while busy is ignored; no queueing.
- abort:
  - effective in any state; next state is IDLE and cnt_clken=0 on the next edge;
  - result registers are not updated;
  - abort in the same cycle as start wins (stays IDLE).
  - abort and result_ack are independent.
- Reset mid-gate forces cnt_clken low asynchronously; the counter's own state is the counter's concern.
- gate_len = 2**GATE_W-1 must not wrap the gate counter.

Optional Feature:
- Macro: GATE_SCHED_OVF_EXTEND_EN.
- When defined:
  - an EXT_W-bit extension register counts overflow rising edges during GATE/SETTLE;
  - the extension saturates at all-ones;
  - result_count = {ext, cnt_count}, width EXT_W+CNTR_WIDTH;
  - result_overflow = 1 only if the extension saturated.
- When undefined:
  - no extension logic;
  - result_count is CNTR_WIDTH bits;
  - result_overflow = any wrap.

Decomposition:
- Shared package/header gate_sched_pkg holds:
  - FSM state encodings S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_DONE (3-bit);
  - default CNTR_WIDTH/GATE_W constants shared with the counter bench.
- One natural sub-module: gate_sched_ovf_ext (edge detect, sticky bit, optional saturating extension counter).
- FSM and timers live in the top.

Test Plan:
- Basic gate:
  - stimulus: gate_len=100, SETTLE_CYC=3, 10 sig_in pulses (20 ns high/40 ns low, 20 ns clk) inside the gate;
  - expected: cnt_clken high exactly 100 cycles, result_valid after 105 cycles, result_count=10, result_overflow=0.
- Wrap:
  - stimulus: CNTR_WIDTH=8, 261 pulses within the gate;
  - expected: result_count=5, result_overflow=1; with GATE_SCHED_OVF_EXTEND_EN, result_count=0x0105, result_overflow=0.
- Zero gate and busy start:
  - stimulus: gate_len=0 start; then a second start during GATE;
  - expected: no CLEAR, busy stays 0 for the first; the second start is ignored and the gate length is unchanged.
- Abort:
  - stimulus: abort at gate cycle 40 of 100;
  - expected: cnt_clken=0 next cycle, IDLE, result_valid stays 0, and the previous result_count is unchanged.
- Handshake:
  - stimulus: hold result_ack=0 for 50 cycles, then pulse it;
  - expected: result_valid stays 1 for the full 50 cycles and drops the cycle after the ack; start is accepted again.
- Reset mid-SETTLE:
  - stimulus: rst_n low for 2 cycles;
  - expected: all outputs 0 immediately (async), IDLE after release.
